// File: rtl/ili9341_spi_stream.sv
// ILI9341 SPI master: init ROM, WIDTH x HEIGHT address window, then RGB565 pixel streaming.
// Define ILI9341_SHORT_DELAY_EN to shorten both init delays to 16 cycles.
module ili9341_spi_stream #(
   parameter int WIDTH     = 240,
   parameter int HEIGHT    = 240,
   parameter int DELAY_CYC = 3_750_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_done,
   input  logic [15:0] input_data,
   output logic        spi_mosi,
   output logic        spi_sck,
   output logic        spi_cs,
   output logic        spi_dc,
   output logic        data_clk
);
`ifdef ILI9341_SHORT_DELAY_EN
   localparam int DLY = 16;
`else
   localparam int DLY = DELAY_CYC;
`endif
   localparam int DLY_W = $clog2(DLY + 1);
   localparam int NPIX  = WIDTH * HEIGHT;
   localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [15:0] W_END = 16'(WIDTH - 1);
   localparam logic [15:0] H_END = 16'(HEIGHT - 1);

   typedef enum logic [2:0] {INIT_SEND, INIT_DELAY, WIN_SEND, PIXEL_STREAM, FRAME_WAIT} state_t;

   state_t           state;
   logic             active;
   logic [3:0]       idx;
   logic [4:0]       cnt;
   logic [4:0]       cnt_nx;
   logic [15:0]      tx;
   logic [DLY_W-1:0] dly;
   logic [PIX_W-1:0] pix_cnt;
   logic [8:0]       rom;

   assign cnt_nx = cnt + 5'd1;

   // {dc, byte} for the command/parameter at idx of the current sequence
   always_comb begin
      rom = 9'h000;
      if (state == INIT_SEND) begin
         case (idx)
            4'd0:    rom = 9'h001;
            4'd1:    rom = 9'h011;
            4'd2:    rom = 9'h03A;
            4'd3:    rom = 9'h155;
            4'd4:    rom = 9'h036;
            4'd5:    rom = 9'h148;
            default: rom = 9'h029;
         endcase
      end else begin
         case (idx)
            4'd0:    rom = 9'h02A;
            4'd1:    rom = 9'h100;
            4'd2:    rom = 9'h100;
            4'd3:    rom = {1'b1, W_END[15:8]};
            4'd4:    rom = {1'b1, W_END[7:0]};
            4'd5:    rom = 9'h02B;
            4'd6:    rom = 9'h100;
            4'd7:    rom = 9'h100;
            4'd8:    rom = {1'b1, H_END[15:8]};
            4'd9:    rom = {1'b1, H_END[7:0]};
            default: rom = 9'h02C;
         endcase
      end
   end

   // Source contract: input_data is sampled on the cycle a pixel starts; data_clk rises
   // in that same cycle and the source answers by presenting the following pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= INIT_SEND;
         active   <= 1'b0;
         idx      <= '0;
         cnt      <= '0;
         tx       <= '0;
         dly      <= '0;
         pix_cnt  <= '0;
         spi_cs   <= 1'b1;
         spi_sck  <= 1'b0;
         spi_mosi <= 1'b0;
         spi_dc   <= 1'b0;
         data_clk <= 1'b0;
      end else begin
         case (state)
            INIT_SEND, WIN_SEND: begin
               if (!active) begin
                  tx       <= {rom[7:0], 8'h00};
                  spi_dc   <= rom[8];
                  spi_mosi <= rom[7];
                  spi_sck  <= 1'b0;
                  spi_cs   <= 1'b0;
                  cnt      <= '0;
                  active   <= 1'b1;
               end else if (cnt == 5'd15) begin
                  active  <= 1'b0;
                  cnt     <= '0;
                  spi_sck <= 1'b0;
                  idx     <= idx + 4'd1;
                  if (state == INIT_SEND && idx <= 4'd1) begin
                     state  <= INIT_DELAY;
                     spi_cs <= 1'b1;
                     dly    <= '0;
                  end else if (state == INIT_SEND && idx == 4'd6) begin
                     state <= WIN_SEND;
                     idx   <= '0;
                  end else if (state == WIN_SEND && idx == 4'd10) begin
                     state <= PIXEL_STREAM;
                     idx   <= '0;
                  end
               end else begin
                  cnt     <= cnt_nx;
                  spi_sck <= cnt_nx[0];
                  if (cnt[0]) begin
                     tx       <= {tx[14:0], 1'b0};
                     spi_mosi <= tx[14];
                  end
               end
            end
            INIT_DELAY: begin
               if (dly == DLY_W'(DLY - 1)) state <= INIT_SEND;
               else                         dly   <= dly + DLY_W'(1);
            end
            PIXEL_STREAM: begin
               if (!active || (cnt == 5'd31 && !frame_done && pix_cnt != PIX_W'(NPIX - 1))) begin
                  tx       <= input_data;
                  spi_mosi <= input_data[15];
                  spi_dc   <= 1'b1;
                  spi_cs   <= 1'b0;
                  spi_sck  <= 1'b0;
                  cnt      <= '0;
                  data_clk <= 1'b1;
                  active   <= 1'b1;
                  if (active) pix_cnt <= pix_cnt + PIX_W'(1);
               end else if (cnt == 5'd31) begin
                  // the pixel just finished is always the last one of this pass
                  active   <= 1'b0;
                  cnt      <= '0;
                  spi_sck  <= 1'b0;
                  data_clk <= 1'b0;
                  pix_cnt  <= '0;
                  if (frame_done) begin
                     state  <= FRAME_WAIT;
                     spi_cs <= 1'b1;
                  end else begin
                     state <= WIN_SEND;
                     idx   <= '0;
                  end
               end else begin
                  cnt      <= cnt_nx;
                  spi_sck  <= cnt_nx[0];
                  data_clk <= ~cnt_nx[4];
                  if (cnt[0]) begin
                     tx       <= {tx[14:0], 1'b0};
                     spi_mosi <= tx[14];
                  end
               end
            end
            FRAME_WAIT: begin
               if (!frame_done) begin
                  state <= WIN_SEND;
                  idx   <= '0;
               end
            end
            default: state <= INIT_SEND;
         endcase
      end
   end
endmodule

// File: tb/tb_ili9341_spi_stream.sv
// Bench for ili9341_spi_stream: decodes the SPI bus into {dc,byte} and scores it against
// a byte-stream model of init, window and pixel traffic; also checks reset, delay and pacing.
`timescale 1ns/1ps
module tb_ili9341_spi_stream;
   localparam int W    = 3;
   localparam int H    = 2;
   localparam int DCYC = 20;
   localparam int NPIX = W * H;
`ifdef ILI9341_SHORT_DELAY_EN
   localparam int DLY = 16;
`else
   localparam int DLY = DCYC;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_done = 1'b0;
   logic [15:0] input_data;
   logic        spi_mosi, spi_sck, spi_cs, spi_dc, data_clk;

   ili9341_spi_stream #(.WIDTH(W), .HEIGHT(H), .DELAY_CYC(DCYC)) dut (
      .clk(clk), .rst(rst), .frame_done(frame_done), .input_data(input_data),
      .spi_mosi(spi_mosi), .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_dc(spi_dc),
      .data_clk(data_clk)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       dc;
      logic [7:0] data;
   } byte_vec_t;

   byte_vec_t   seq_tbl[18];
   logic [8:0]  exp_q[$];
   logic [15:0] pix_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic        const_px = 1'b1;
   logic        pix_mode = 1'b0;
   logic        pix_half = 1'b0;
   int          pix_in_frame = 0;
   int          last_frame_pix = 0;
   int          frames = 0;
   int          bit_n = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string why);
      n_vec++;
      n_err++;
      $display("FAIL %s: %s", name, why);
   endtask

   task automatic push_window();
      for (int i = 7; i < 18; i++) exp_q.push_back({seq_tbl[i].dc, seq_tbl[i].data});
   endtask

   task automatic push_all();
      for (int i = 0; i < 18; i++) exp_q.push_back({seq_tbl[i].dc, seq_tbl[i].data});
   endtask

   // Reference model: command bytes come from exp_q; once it drains, pixels follow
   // until a frame ends (frame_done at the boundary or NPIX pixels), then the window again.
   task automatic got_byte(input logic dc, input logic [7:0] b);
      logic [8:0] e;
      if (!pix_mode) begin
         if (exp_q.size() == 0) begin
            fail("stream byte", $sformatf("got dc=%0d data=0x%02h, want no byte", dc, b));
         end else begin
            e = exp_q.pop_front();
            check("cmd/param {dc,data}", {23'd0, dc, b}, {23'd0, e});
            if (exp_q.size() == 0) begin
               pix_mode = 1'b1;
               pix_half = 1'b0;
            end
         end
      end else if (pix_q.size() == 0) begin
         fail("pixel byte", $sformatf("got 0x%02h, want none (no pixel presented)", b));
      end else if (!pix_half) begin
         check("pixel hi {dc,data}", {23'd0, dc, b}, {23'd0, 1'b1, pix_q[0][15:8]});
         pix_half = 1'b1;
      end else begin
         check("pixel lo {dc,data}", {23'd0, dc, b}, {23'd0, 1'b1, pix_q[0][7:0]});
         pix_q.delete(0);
         pix_half = 1'b0;
         pix_in_frame++;
         if (frame_done || pix_in_frame == NPIX) begin
            last_frame_pix = pix_in_frame;
            pix_in_frame   = 0;
            frames++;
            pix_mode = 1'b0;
            push_window();
         end
      end
   endtask

   // Bus monitor: one bit per sck rising edge, framing checked per byte
   logic       sck_q = 1'b0;
   logic [7:0] sh = '0;
   logic       dc0 = 1'b0;
   logic       frame_ok = 1'b0;
   int         last_t = 0;
   always @(negedge clk) begin
      if (rst) begin
         bit_n = 0;
      end else if (spi_sck && !sck_q) begin
         if (bit_n == 0) begin
            dc0      = spi_dc;
            frame_ok = !spi_cs;
         end else begin
            frame_ok = frame_ok && (cyc - last_t == 2) && (spi_dc == dc0) && !spi_cs;
         end
         last_t = cyc;
         sh = {sh[6:0], spi_mosi};
         bit_n++;
         if (bit_n == 8) begin
            bit_n = 0;
            check("byte framing (cs low, dc held, sck period 2)", {31'd0, frame_ok}, 32'd1);
            got_byte(dc0, sh);
         end
      end
      sck_q = spi_sck;
   end

   // Pixel source: presents the next pixel on each data_clk rising edge
   initial begin
      logic dclk_q;
      dclk_q     = 1'b0;
      input_data = 16'hF800;
      pix_q.push_back(input_data);
      forever begin
         @(negedge clk);
         if (data_clk && !dclk_q) begin
            input_data = const_px ? 16'hF800 : 16'($urandom);
            pix_q.push_back(input_data);
         end
         dclk_q = data_clk;
      end
   end

   function automatic logic probe(input int which);
      case (which)
         0:       return spi_cs;
         1:       return data_clk;
         default: return pix_mode;
      endcase
   endfunction

   task automatic wait_for(input string name, input int which, input logic val, input int budget);
      int k;
      k = 0;
      while (probe(which) !== val && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (probe(which) !== val) fail(name, $sformatf("timeout after %0d cycles, want level %0d", budget, val));
   endtask

   task automatic reset_model();
      exp_q.delete();
      pix_mode     = 1'b0;
      pix_half     = 1'b0;
      pix_in_frame = 0;
      while (pix_q.size() > 1) pix_q.delete(0);
      push_all();
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, t2, run, f0, hold, k;
      seq_tbl[0]  = '{1'b0, 8'h01};
      seq_tbl[1]  = '{1'b0, 8'h11};
      seq_tbl[2]  = '{1'b0, 8'h3A};
      seq_tbl[3]  = '{1'b1, 8'h55};
      seq_tbl[4]  = '{1'b0, 8'h36};
      seq_tbl[5]  = '{1'b1, 8'h48};
      seq_tbl[6]  = '{1'b0, 8'h29};
      seq_tbl[7]  = '{1'b0, 8'h2A};
      seq_tbl[8]  = '{1'b1, 8'h00};
      seq_tbl[9]  = '{1'b1, 8'h00};
      seq_tbl[10] = '{1'b1, 8'((W - 1) / 256)};
      seq_tbl[11] = '{1'b1, 8'((W - 1) % 256)};
      seq_tbl[12] = '{1'b0, 8'h2B};
      seq_tbl[13] = '{1'b1, 8'h00};
      seq_tbl[14] = '{1'b1, 8'h00};
      seq_tbl[15] = '{1'b1, 8'((H - 1) / 256)};
      seq_tbl[16] = '{1'b1, 8'((H - 1) % 256)};
      seq_tbl[17] = '{1'b0, 8'h2C};

      // reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset cs", spi_cs, 1);
      check("reset sck", spi_sck, 0);
      check("reset mosi", spi_mosi, 0);
      check("reset dc", spi_dc, 0);
      check("reset data_clk", data_clk, 0);
      reset_model();
      rst = 1'b0;

      // both init delays hold cs high for about DLY cycles
      for (int d = 0; d < 2; d++) begin
         wait_for("cs low before delay", 0, 1'b0, 200);
         wait_for("cs high for delay", 0, 1'b1, 200);
         run = 0;
         while (spi_cs && run < 500) begin
            @(negedge clk);
            run++;
         end
         check("init delay length in range", {31'd0, (run >= DLY && run <= DLY + 2)}, 32'd1);
      end

      // data_clk pacing on the first frame (constant 0xF800)
      wait_for("pixels start", 2, 1'b1, 1000);
      wait_for("data_clk rise", 1, 1'b1, 100);
      t0 = cyc;
      wait_for("data_clk fall", 1, 1'b0, 100);
      t1 = cyc;
      wait_for("data_clk next rise", 1, 1'b1, 100);
      t2 = cyc;
      check("data_clk high cycles", t1 - t0, 16);
      check("data_clk period", t2 - t0, 32);

      // full frame wraps into a new window sequence
      k = 0;
      while (frames < 1 && k < 600) begin
         @(negedge clk);
         k++;
      end
      check("frame wrapped after NPIX pixels", frames, 1);
      const_px = 1'b0;

      // frame_done raised mid-pixel: that pixel completes, then cs rises
      wait_for("pixels resume", 2, 1'b1, 600);
      wait_for("data_clk rise (mid-pixel test)", 1, 1'b1, 100);
      repeat ($urandom_range(2, 25)) @(negedge clk);
      f0 = frames;
      frame_done = 1'b1;
      wait_for("cs high at pixel boundary", 0, 1'b1, 60);
      check("current pixel completed before cs rose", frames, f0 + 1);
      check("data_clk low in frame wait", data_clk, 0);
      hold = 0;
      repeat (30) begin
         @(negedge clk);
         if (spi_cs && !data_clk && !spi_sck) hold++;
      end
      check("bus idle while frame_done held", hold, 30);
      frame_done = 1'b0;

      // frame_done already set at the first boundary: exactly one pixel
      wait_for("window resent, pixels resume", 2, 1'b1, 600);
      frame_done = 1'b1;
      wait_for("cs high after single pixel", 0, 1'b1, 80);
      check("pixels in single-pixel frame", last_frame_pix, 1);
      frame_done = 1'b0;

      // reset while streaming, then again in the middle of C3A
      wait_for("pixels resume again", 2, 1'b1, 600);
      repeat ($urandom_range(5, 60)) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      reset_model();
      rst = 1'b0;
      k = 0;
      while (!(exp_q.size() > 0 && exp_q[0] == 9'h03A && bit_n >= 3) && k < 600) begin
         @(negedge clk);
         k++;
      end
      check("reached mid C3A byte", {31'd0, (bit_n >= 3)}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("cs one cycle after mid-byte reset", spi_cs, 1);
      check("sck one cycle after mid-byte reset", spi_sck, 0);
      repeat (2) @(negedge clk);
      reset_model();
      rst = 1'b0;
      k = 0;
      while (exp_q.size() > 15 && k < 600) begin
         @(negedge clk);
         k++;
      end
      check("restart bytes 01,11,3A seen", {31'd0, (exp_q.size() <= 15)}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
